alu_result_stage: RTL and testbench

- Pipeline stage directly downstream of the 16-bit ALU.
- Captures the ALU result, SZCV flags, destination register and write enables into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Maintains the architectural SZCV flag register.
- Resolves conditional branches (BE/BLT/BLE/BNE) against the committed flags.
- Feeds register-file writeback and PC-select logic.

---
 rtl/alu_result_stage.sv | 173 +++++++++++++++++
 tb/tb_alu_result_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//
// Pipeline stage directly downstream of the 16-bit ALU. Each ALU entry holds
// a result, a destination register, a write enable and a branch outcome. The
// stage keeps these entries in a 2-entry skid buffer. It has valid/ready
// handshakes on both sides. The stage also owns the architectural SZCV flag
// register and resolves conditional branches when an entry is accepted.
//
// Optional feature (define ALU_RESULT_STAGE_RETIRE_CNT_EN):
//    adds retire_cnt, a saturating 16-bit count of retired entries that wrote
//    the register file.
//
// Ports:
//    clk           rising-edge clock
//    rst           synchronous, active-low reset
//    in_valid      ALU-side entry valid
//    in_ready      stage can accept an entry this cycle (registered)
//    in_result     ALU result
//    in_szcv       ALU flags {S,Z,C,V}
//    in_rd         destination register index
//    in_we         entry writes the register file
//    in_flag_we    entry updates the flag register
//    in_br_cond    0=none 1=B 2=BE 3=BLT 4=BLE 5=BNE (6,7 = none)
//    out_valid     head entry valid
//    out_ready     writeback accepts the head entry
//    out_result    head result
//    out_rd        head destination register
//    out_we        head register write enable (0 when out_valid=0)
//    out_br_taken  head entry is a taken branch (0 when out_valid=0)
//    flags         committed SZCV register
//    retire_cnt    (optional) saturating count of register-writing retires
// ---------------------------------------------------------------------------
module alu_result_stage #(
   parameter int DATA_W = 16,
   parameter int RD_W   = 3,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [3:0]        in_szcv,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              in_we,
   input  logic              in_flag_we,
   input  logic [2:0]        in_br_cond,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_we,
   output logic              out_br_taken,
   output logic [3:0]        flags
`ifdef ALU_RESULT_STAGE_RETIRE_CNT_EN
   ,
   output logic [15:0]       retire_cnt
`endif
);

   // The buffer always has two slots. A 1-bit head pointer and a 1-bit tail
   // pointer are enough to address them.
   localparam int SLOTS = DEPTH;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic              head_q;
   logic              tail_q;
   logic [DATA_W-1:0] slot_result [SLOTS];
   logic [RD_W-1:0]   slot_rd     [SLOTS];
   logic              slot_we     [SLOTS];
   logic              slot_br     [SLOTS];

   logic accept;
   logic retire;
   logic br_taken;

   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q != EMPTY);
   assign retire    = out_valid & out_ready;

   // The outputs come only from stored slots, so there is no combinational
   // path from the ALU side to the writeback side.
   assign out_result   = slot_result[head_q];
   assign out_rd       = slot_rd[head_q];
   assign out_we       = out_valid & slot_we[head_q];
   assign out_br_taken = out_valid & slot_br[head_q];

   // Occupancy next-state logic. In FULL, in_ready is low, so accept cannot
   // happen there. At ONE, a simultaneous accept and retire keeps the
   // occupancy at one.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) state_d = ONE;
         end
         ONE: begin
            if (accept && !retire)      state_d = FULL;
            else if (!accept && retire) state_d = EMPTY;
         end
         FULL: begin
            if (retire) state_d = ONE;
         end
         default: state_d = EMPTY;
      endcase
   end

   // Branch resolution uses the flags committed before this edge. An entry
   // that also writes flags therefore tests the old values.
   always_comb begin
      br_taken = 1'b0;
      case (in_br_cond)
         3'd1: br_taken = 1'b1;
         3'd2: br_taken = flags[2];
         3'd3: br_taken = flags[3] ^ flags[0];
         3'd4: br_taken = flags[2] | (flags[3] ^ flags[0]);
         3'd5: br_taken = ~flags[2];
         default: br_taken = 1'b0;
      endcase
   end

   // Buffer storage, pointers, flag register and the registered ready.
   // in_ready looks at the next occupancy, so it only depends on registered
   // state and never on out_ready within the same cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= EMPTY;
         in_ready <= 1'b0;
         head_q   <= 1'b0;
         tail_q   <= 1'b0;
         flags    <= 4'b0000;
         for (int i = 0; i < SLOTS; i++) begin
            slot_result[i] <= '0;
            slot_rd[i]     <= '0;
            slot_we[i]     <= 1'b0;
            slot_br[i]     <= 1'b0;
         end
      end else begin
         state_q  <= state_d;
         in_ready <= (state_d != FULL);
         if (accept) begin
            slot_result[tail_q] <= in_result;
            slot_rd[tail_q]     <= in_rd;
            slot_we[tail_q]     <= in_we;
            slot_br[tail_q]     <= br_taken;
            tail_q              <= ~tail_q;
            if (in_flag_we) flags <= in_szcv;
         end
         if (retire) head_q <= ~head_q;
      end
   end

`ifdef ALU_RESULT_STAGE_RETIRE_CNT_EN
   // The count holds at all ones instead of wrapping back to zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         retire_cnt <= 16'h0000;
      end else if (retire && out_we && (retire_cnt != 16'hFFFF)) begin
         retire_cnt <= retire_cnt + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
//
// Bench for alu_result_stage. The expected head entries are kept in a queue.
// An entry is pushed when it is accepted and popped when it retires. A small
// model tracks the flag register and in_ready. Branch outcomes come from
// hand-derived values in the vector table.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic [3:0]  in_szcv;
   logic [2:0]  in_rd;
   logic        in_we;
   logic        in_flag_we;
   logic [2:0]  in_br_cond;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [2:0]  out_rd;
   logic        out_we;
   logic        out_br_taken;
   logic [3:0]  flags;
`ifdef ALU_RESULT_STAGE_RETIRE_CNT_EN
   logic [15:0] retire_cnt;
   logic [15:0] model_rcnt;
`endif

   typedef struct {
      logic [15:0] result;
      logic [3:0]  szcv;
      logic [2:0]  rd;
      logic        we;
      logic        flag_we;
      logic [2:0]  br;
      logic        exp_br;
      logic [3:0]  exp_flags;
   } vec_t;

   typedef struct {
      logic [15:0] result;
      logic [2:0]  rd;
      logic        we;
      logic        br;
   } exp_t;

   exp_t       sb[$];
   exp_t       pend;
   logic [3:0] model_flags;
   logic       model_ready;
   bit         mon_en = 1'b0;
   int         n_compared = 0;
   int         n_mismatched = 0;
   vec_t       vecs[18];

   always #5 clk = ~clk;

   alu_result_stage #(.DATA_W(16), .RD_W(3), .DEPTH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_result   (in_result),
      .in_szcv     (in_szcv),
      .in_rd       (in_rd),
      .in_we       (in_we),
      .in_flag_we  (in_flag_we),
      .in_br_cond  (in_br_cond),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_rd      (out_rd),
      .out_we      (out_we),
      .out_br_taken(out_br_taken),
      .flags       (flags)
`ifdef ALU_RESULT_STAGE_RETIRE_CNT_EN
      ,
      .retire_cnt  (retire_cnt)
`endif
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one entry, starting #1 after a rising edge. It holds in_valid
   // until the entry is accepted, then returns #1 after the accepting edge.
   task automatic applyStimulus(input vec_t v);
      bit accepted = 1'b0;
      in_result   = v.result;
      in_szcv     = v.szcv;
      in_rd       = v.rd;
      in_we       = v.we;
      in_flag_we  = v.flag_we;
      in_br_cond  = v.br;
      pend.result = v.result;
      pend.rd     = v.rd;
      pend.we     = v.we;
      pend.br     = v.exp_br;
      in_valid    = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            @(posedge clk);
            #1;
            accepted = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!accepted) checkOutput("accept_timeout", 32'(accepted), 32'd1);
   endtask

   task automatic waitDrain(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
         #1;
      end
      checkOutput("drain", 32'(sb.size()), 32'd0);
   endtask

   function automatic vec_t mk(input logic [15:0] r, input logic [3:0] s, input logic [2:0] rd,
                               input logic we, input logic fwe, input logic [2:0] br,
                               input logic eb, input logic [3:0] ef);
      vec_t v;
      v.result = r; v.szcv = s; v.rd = rd; v.we = we; v.flag_we = fwe;
      v.br = br; v.exp_br = eb; v.exp_flags = ef;
      return v;
   endfunction

   // The monitor samples on the falling edge. It compares the DUT against
   // the model, then advances the model by the handshakes that the next
   // rising edge will perform.
   always @(negedge clk) begin
      if (mon_en) begin
         checkOutput("flags", 32'(flags), 32'(model_flags));
         checkOutput("in_ready", 32'(in_ready), 32'(model_ready));
         checkOutput("out_valid", 32'(out_valid), 32'(sb.size() != 0));
         if (sb.size() != 0) begin
            checkOutput("out_result", 32'(out_result), 32'(sb[0].result));
            checkOutput("out_rd", 32'(out_rd), 32'(sb[0].rd));
            checkOutput("out_we", 32'(out_we), 32'(sb[0].we));
            checkOutput("out_br_taken", 32'(out_br_taken), 32'(sb[0].br));
         end else begin
            checkOutput("idle_out_we", 32'(out_we), 32'd0);
            checkOutput("idle_out_br_taken", 32'(out_br_taken), 32'd0);
         end
`ifdef ALU_RESULT_STAGE_RETIRE_CNT_EN
         checkOutput("retire_cnt", 32'(retire_cnt), 32'(model_rcnt));
`endif
         if (!rst) begin
            sb.delete();
            model_flags = 4'b0000;
            model_ready = 1'b0;
`ifdef ALU_RESULT_STAGE_RETIRE_CNT_EN
            model_rcnt = 16'h0000;
`endif
         end else begin
            if (sb.size() != 0 && out_ready) begin
`ifdef ALU_RESULT_STAGE_RETIRE_CNT_EN
               if (sb[0].we && model_rcnt != 16'hFFFF) model_rcnt = model_rcnt + 16'h0001;
`endif
               void'(sb.pop_front());
            end
            if (in_valid && model_ready) begin
               sb.push_back(pend);
               if (in_flag_we) model_flags = in_szcv;
            end
            model_ready = (sb.size() < 2);
         end
      end
   end

   initial begin
      vec_t v;
      rst = 1'b0; in_valid = 1'b0; in_result = '0; in_szcv = '0; in_rd = '0;
      in_we = 1'b0; in_flag_we = 1'b0; in_br_cond = '0; out_ready = 1'b0;
      model_flags = 4'b0000; model_ready = 1'b0;
      pend.result = '0; pend.rd = '0; pend.we = 1'b0; pend.br = 1'b0;
`ifdef ALU_RESULT_STAGE_RETIRE_CNT_EN
      model_rcnt = 16'h0000;
`endif

      // Branch vectors. The flag bits are {S,Z,C,V}. exp_br is resolved
      // against the flags from before that entry.
      vecs[0]  = mk(16'h0000, 4'b0100, 3'd3, 1'b1, 1'b1, 3'd0, 1'b0, 4'b0100);
      vecs[1]  = mk(16'h1234, 4'b0000, 3'd1, 1'b0, 1'b0, 3'd2, 1'b1, 4'b0100);
      vecs[2]  = mk(16'h00AA, 4'b0001, 3'd2, 1'b1, 1'b1, 3'd0, 1'b0, 4'b0001);
      vecs[3]  = mk(16'h0003, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 4'b0001);
      vecs[4]  = mk(16'h0004, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 4'b0001);
      vecs[5]  = mk(16'h0005, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd2, 1'b0, 4'b0001);
      vecs[6]  = mk(16'h0006, 4'b0000, 3'd4, 1'b1, 1'b1, 3'd0, 1'b0, 4'b0000);
      vecs[7]  = mk(16'h0007, 4'b0100, 3'd5, 1'b0, 1'b1, 3'd4, 1'b0, 4'b0100);
      vecs[8]  = mk(16'h0008, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 4'b0100);
      vecs[9]  = mk(16'h0009, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd6, 1'b0, 4'b0100);
      vecs[10] = mk(16'h000A, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0, 4'b0100);
      vecs[11] = mk(16'h000B, 4'b1000, 3'd6, 1'b1, 1'b1, 3'd2, 1'b1, 4'b1000);
      vecs[12] = mk(16'h000C, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 4'b1000);
      vecs[13] = mk(16'h000D, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1, 4'b1000);
      vecs[14] = mk(16'h000E, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 4'b1000);
      vecs[15] = mk(16'h000F, 4'b1001, 3'd7, 1'b1, 1'b1, 3'd0, 1'b0, 4'b1001);
      vecs[16] = mk(16'h0010, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd3, 1'b0, 4'b1001);
      vecs[17] = mk(16'h0011, 4'b0000, 3'd0, 1'b0, 1'b0, 3'd4, 1'b0, 4'b1001);

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_flags", 32'(flags), 32'd0);
      checkOutput("rst_out_result", 32'(out_result), 32'd0);
      checkOutput("rst_out_rd", 32'(out_rd), 32'd0);
      checkOutput("rst_out_we", 32'(out_we), 32'd0);
      checkOutput("rst_out_br_taken", 32'(out_br_taken), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);

      // Flags and branch resolution.
      out_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].exp_flags));
      end
      waitDrain(10);

      // Backpressure fill. The head holds steady while the buffer is full.
      out_ready = 1'b0;
      applyStimulus(mk(16'h1111, 4'b0000, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 4'b1001));
      applyStimulus(mk(16'h2222, 4'b0000, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 4'b1001));
      checkOutput("full_in_ready", 32'(in_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("full_head_hold", 32'(out_result), 32'h1111);
      out_ready = 1'b1;
      waitDrain(10);
      checkOutput("drained_in_ready", 32'(in_ready), 32'd1);

      // Streaming: accept and retire in the same cycle at occupancy one.
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(mk(16'(i), 4'b0000, 3'(i), 1'b1, 1'b0, 3'd0, 1'b0, 4'b1001));
         checkOutput($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
      end
      waitDrain(10);

      // Reset while full and with out_ready high. The reset edge must not
      // retire anything.
      out_ready = 1'b0;
      applyStimulus(mk(16'h0505, 4'b1111, 3'd5, 1'b1, 1'b1, 3'd0, 1'b0, 4'b1111));
      applyStimulus(mk(16'h0606, 4'b1111, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 4'b1111));
      rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_flags", 32'(flags), 32'd0);
      checkOutput("midrst_out_result", 32'(out_result), 32'd0);
      checkOutput("midrst_out_rd", 32'(out_rd), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("midrst_no_stale", 32'(out_valid), 32'd0);

`ifdef ALU_RESULT_STAGE_RETIRE_CNT_EN
      // Retire counter: only register-writing retires count, and the count
      // saturates.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(mk(16'(i), 4'b0000, 3'd1, (i < 3) ? 1'b1 : 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000));
      end
      waitDrain(10);
      checkOutput("retire_cnt_3", 32'(retire_cnt), 32'd3);
      for (int i = 0; i < 65535; i++) begin
         v = mk(16'(i), 4'b0000, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0000);
         applyStimulus(v);
      end
      waitDrain(10);
      checkOutput("retire_cnt_sat", 32'(retire_cnt), 32'h0000FFFF);
      applyStimulus(mk(16'h7777, 4'b0000, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0000));
      waitDrain(10);
      checkOutput("retire_cnt_hold", 32'(retire_cnt), 32'h0000FFFF);
`endif

      @(posedge clk);
      #1;
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
